// File: rtl/lpif_rx_align_pkg.sv
// Shared types and bit locations for the LPIF AIB receive alignment monitor.
// The strobe/marker bit pick lives here so every consumer agrees on locations.
package lpif_rx_align_pkg;

  localparam int unsigned RX_CH_WIDTH  = 80;
  localparam int unsigned GEN2_STB_LOC = 1;
  localparam int unsigned GEN2_MRK_LOC = 77;
  localparam int unsigned GEN1_STB_LOC = 38;
  localparam int unsigned GEN1_MRK_LOC = 39;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } rx_align_state_e;

  // Returns {marker, strobe} taken from the generation-specific locations.
  function automatic logic [1:0] pick_stb_mrk(input logic [RX_CH_WIDTH-1:0] word,
                                              input logic                   gen2);
    logic [1:0] res;
    if (gen2) begin
      res = {word[GEN2_MRK_LOC], word[GEN2_STB_LOC]};
    end else begin
      res = {word[GEN1_MRK_LOC], word[GEN1_STB_LOC]};
    end
    return res;
  endfunction

endpackage

// File: rtl/lpif_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lpif_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lpif_rx_align_monitor.sv
// RX alignment monitor: checks strobe/marker on the raw PHY word, runs hunt/lock,
// forwards a registered word with valid, and counts bad words seen while locked.
module lpif_rx_align_monitor
  import lpif_rx_align_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter logic        STB_EXP    = 1'b1,
  parameter logic        MRK_EXP    = 1'b1,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                   clk_rd,
  input  logic                   rst_rd_n,
  input  logic [RX_CH_WIDTH-1:0] rx_phy0,
  input  logic                   m_gen2_mode,
  input  logic                   rx_online,
  input  logic                   rx_err_cnt_clr,
  output logic [RX_CH_WIDTH-1:0] rx_phy_q,
  output logic                   rx_word_valid,
  output logic                   rx_align_lock,
  output logic                   rx_stb_err,
  output logic                   rx_mrk_err,
  output logic [ERR_W-1:0]       rx_err_cnt
);

  localparam int unsigned RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  rx_align_state_e  state_q, state_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;
  logic [RUN_W-1:0] bad_run_q, bad_run_d;

  logic [RX_CH_WIDTH-1:0] phy_q;
  logic                   valid_q, valid_d;
  logic                   lock_q;
  logic                   stb_err_q, mrk_err_q;

  logic [1:0] sm_s;
  logic       stb_bad_s;
  logic       mrk_bad_s;
  logic       good_s;
  logic       err_inc_s;

  assign sm_s      = pick_stb_mrk(rx_phy0, m_gen2_mode);
  assign stb_bad_s = (sm_s[0] != STB_EXP);
  assign mrk_bad_s = (sm_s[1] != MRK_EXP);
  assign good_s    = !stb_bad_s && !mrk_bad_s;

  // Hunt/lock next-state, run counters, word-valid and error-increment decode.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    valid_d    = 1'b0;
    err_inc_s  = 1'b0;
    if (!rx_online) begin
      state_d    = ST_IDLE;
      good_run_d = {RUN_W{1'b0}};
      bad_run_d  = {RUN_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_HUNT;
          good_run_d = {RUN_W{1'b0}};
          bad_run_d  = {RUN_W{1'b0}};
        end
        ST_HUNT: begin
          if (!good_s) begin
            good_run_d = {RUN_W{1'b0}};
          end else if ((good_run_q + RUN_W'(1)) == RUN_W'(LOCK_CNT)) begin
            state_d    = ST_LOCKED;
            good_run_d = {RUN_W{1'b0}};
            bad_run_d  = {RUN_W{1'b0}};
          end else begin
            good_run_d = good_run_q + RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          if (good_s) begin
            bad_run_d = {RUN_W{1'b0}};
            valid_d   = 1'b1;
          end else begin
            err_inc_s = 1'b1;
            // The unlocking word itself is still counted as an error.
            if ((bad_run_q + RUN_W'(1)) == RUN_W'(UNLOCK_CNT)) begin
              state_d    = ST_HUNT;
              bad_run_d  = {RUN_W{1'b0}};
              good_run_d = {RUN_W{1'b0}};
            end else begin
              bad_run_d = bad_run_q + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_run_d = {RUN_W{1'b0}};
          bad_run_d  = {RUN_W{1'b0}};
        end
      endcase
    end
  end

  // State and run-counter registers.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      state_q    <= ST_IDLE;
      good_run_q <= {RUN_W{1'b0}};
      bad_run_q  <= {RUN_W{1'b0}};
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
    end
  end

  // Output registers, all aligned to the word sampled at the previous edge.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      phy_q     <= {RX_CH_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      stb_err_q <= 1'b0;
      mrk_err_q <= 1'b0;
    end else begin
      phy_q     <= rx_phy0;
      valid_q   <= valid_d;
      lock_q    <= (state_d == ST_LOCKED);
      stb_err_q <= rx_online && stb_bad_s;
      mrk_err_q <= rx_online && mrk_bad_s;
    end
  end

  lpif_sat_cnt #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk_i   (clk_rd),
    .rst_n_i (rst_rd_n),
    .inc_i   (err_inc_s),
    .clr_i   (rx_err_cnt_clr),
    .cnt_o   (rx_err_cnt)
  );

  assign rx_phy_q      = phy_q;
  assign rx_word_valid = valid_q;
  assign rx_align_lock = lock_q;
  assign rx_stb_err    = stb_err_q;
  assign rx_mrk_err    = mrk_err_q;

endmodule

// File: tb/tb_lpif_rx_align_monitor.sv
// Directed bench: default-parameter instance plus an ERR_W=4 / UNLOCK_CNT=255 instance
// sharing the word stream; expected values are hand-derived constants.
module tb_lpif_rx_align_monitor;

  localparam logic [79:0] GOOD2    = (80'd1 << 77) | (80'd1 << 1);
  localparam logic [79:0] BAD_MRK2 = (80'd1 << 1);
  localparam logic [79:0] BAD_STB2 = (80'd1 << 77);
  localparam logic [79:0] GOOD1    = (80'd1 << 39) | (80'd1 << 38);

  logic        clk;
  logic        rst_n;
  logic        rst_b_n;
  logic [79:0] rx_phy0;
  logic        m_gen2_mode;
  logic        rx_online;
  logic        clr_a;
  logic        clr_b;

  logic [79:0] phy_q_a, phy_q_b;
  logic        valid_a, valid_b;
  logic        lock_a, lock_b;
  logic        stb_err_a, stb_err_b;
  logic        mrk_err_a, mrk_err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks;
  int n_errors;

  lpif_rx_align_monitor u_dut_a (
    .clk_rd         (clk),
    .rst_rd_n       (rst_n),
    .rx_phy0        (rx_phy0),
    .m_gen2_mode    (m_gen2_mode),
    .rx_online      (rx_online),
    .rx_err_cnt_clr (clr_a),
    .rx_phy_q       (phy_q_a),
    .rx_word_valid  (valid_a),
    .rx_align_lock  (lock_a),
    .rx_stb_err     (stb_err_a),
    .rx_mrk_err     (mrk_err_a),
    .rx_err_cnt     (cnt_a)
  );

  lpif_rx_align_monitor #(
    .LOCK_CNT   (8),
    .UNLOCK_CNT (255),
    .ERR_W      (4)
  ) u_dut_b (
    .clk_rd         (clk),
    .rst_rd_n       (rst_b_n),
    .rx_phy0        (rx_phy0),
    .m_gen2_mode    (m_gen2_mode),
    .rx_online      (rx_online),
    .rx_err_cnt_clr (clr_b),
    .rx_phy_q       (phy_q_b),
    .rx_word_valid  (valid_b),
    .rx_align_lock  (lock_b),
    .rx_stb_err     (stb_err_b),
    .rx_mrk_err     (mrk_err_b),
    .rx_err_cnt     (cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [79:0] w);
    rx_phy0 = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    rst_b_n     = 1'b0;
    rx_phy0     = 80'd0;
    m_gen2_mode = 1'b1;
    rx_online   = 1'b0;
    clr_a       = 1'b0;
    clr_b       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_phy_q", phy_q_a, 80'd0);
    check_eq("rst_valid", 80'(valid_a), 80'd0);
    check_eq("rst_lock", 80'(lock_a), 80'd0);
    check_eq("rst_errs", 80'({stb_err_a, mrk_err_a}), 80'd0);
    check_eq("rst_cnt", 80'(cnt_a), 80'd0);
    rst_n   = 1'b1;
    rst_b_n = 1'b1;
    step(80'd0);

    // Gen2 lock from IDLE: lock after the 9th edge, valid from the 10th.
    rx_online = 1'b1;
    for (int i = 0; i < 8; i++) step(GOOD2);
    check_eq("lock_not_yet", 80'(lock_a), 80'd0);
    step(GOOD2);
    check_eq("lock_at_9", 80'(lock_a), 80'd1);
    check_eq("entry_word_invalid", 80'(valid_a), 80'd0);
    step(GOOD2);
    check_eq("valid_after_lock", 80'(valid_a), 80'd1);
    check_eq("phy_q_word", phy_q_a, GOOD2);

    // Online drop, then hunt with a bad marker on word 8 restarting the run.
    rx_online = 1'b0;
    step(GOOD2);
    check_eq("offline_lock", 80'(lock_a), 80'd0);
    check_eq("offline_valid", 80'(valid_a), 80'd0);
    rx_online = 1'b1;
    step(GOOD2);
    for (int i = 0; i < 7; i++) step(GOOD2);
    step(BAD_MRK2);
    check_eq("hunt_bad_mrk", 80'({stb_err_a, mrk_err_a}), 80'b01);
    for (int i = 0; i < 7; i++) step(GOOD2);
    check_eq("hunt_restart_nolock", 80'(lock_a), 80'd0);
    step(GOOD2);
    check_eq("hunt_restart_lock", 80'(lock_a), 80'd1);
    check_eq("hunt_no_errcnt", 80'(cnt_a), 80'd0);

    // Locked: five rounds of 3 bad + 1 good keeps lock and counts 15 errors.
    for (int r = 0; r < 5; r++) begin
      step(BAD_STB2);
      check_eq("burst_stb_err", 80'({stb_err_a, mrk_err_a}), 80'b10);
      check_eq("burst_bad_invalid", 80'(valid_a), 80'd0);
      step(BAD_MRK2);
      check_eq("burst_mrk_err", 80'({stb_err_a, mrk_err_a}), 80'b01);
      step(80'd0);
      check_eq("burst_lock_held", 80'(lock_a), 80'd1);
      step(GOOD2);
      check_eq("burst_good_valid", 80'(valid_a), 80'd1);
    end
    check_eq("burst_errcnt", 80'(cnt_a), 80'd15);

    // Clear, then 4 bad words unlock into HUNT; relock needs only 8 good words.
    clr_a = 1'b1;
    step(GOOD2);
    clr_a = 1'b0;
    check_eq("clr_errcnt", 80'(cnt_a), 80'd0);
    for (int i = 0; i < 3; i++) step(BAD_STB2);
    check_eq("unlock_held_3", 80'(lock_a), 80'd1);
    step(BAD_STB2);
    check_eq("unlock_at_4", 80'(lock_a), 80'd0);
    check_eq("unlock_errcnt", 80'(cnt_a), 80'd4);
    check_eq("unlock_word_invalid", 80'(valid_a), 80'd0);
    for (int i = 0; i < 7; i++) step(GOOD2);
    check_eq("relock_not_yet", 80'(lock_a), 80'd0);
    step(GOOD2);
    check_eq("relock_from_hunt", 80'(lock_a), 80'd1);

    // Gen1 locations lock; the same words under Gen2 never lock.
    rx_online = 1'b0;
    step(GOOD1);
    m_gen2_mode = 1'b0;
    rx_online   = 1'b1;
    for (int i = 0; i < 8; i++) step(GOOD1);
    check_eq("gen1_not_yet", 80'(lock_a), 80'd0);
    step(GOOD1);
    check_eq("gen1_lock", 80'(lock_a), 80'd1);
    rx_online = 1'b0;
    step(GOOD1);
    m_gen2_mode = 1'b1;
    rx_online   = 1'b1;
    for (int i = 0; i < 20; i++) step(GOOD1);
    check_eq("gen2_no_lock", 80'(lock_a), 80'd0);
    check_eq("gen2_both_err", 80'({stb_err_a, mrk_err_a}), 80'b11);
    check_eq("gen2_hunt_errcnt", 80'(cnt_a), 80'd4);

    // Narrow counter: saturate, clear beats increment, then async reset.
    rx_online = 1'b0;
    step(GOOD2);
    rst_b_n = 1'b0;
    #1;
    check_eq("b_rst_cnt", 80'(cnt_b), 80'd0);
    rst_b_n   = 1'b1;
    rx_online = 1'b1;
    for (int i = 0; i < 9; i++) step(GOOD2);
    check_eq("b_lock", 80'(lock_b), 80'd1);
    for (int i = 0; i < 15; i++) step(BAD_MRK2);
    check_eq("b_cnt_15", 80'(cnt_b), 80'd15);
    for (int i = 0; i < 5; i++) step(BAD_MRK2);
    check_eq("b_cnt_sat", 80'(cnt_b), 80'd15);
    check_eq("b_lock_held", 80'(lock_b), 80'd1);
    check_eq("a_unlocked", 80'(lock_a), 80'd0);
    check_eq("a_cnt", 80'(cnt_a), 80'd8);
    clr_b = 1'b1;
    step(BAD_MRK2);
    clr_b = 1'b0;
    check_eq("b_clr_wins", 80'(cnt_b), 80'd0);
    step(BAD_MRK2);
    check_eq("b_cnt_after_clr", 80'(cnt_b), 80'd1);
    #2;
    rst_b_n = 1'b0;
    #1;
    check_eq("b_async_phy_q", phy_q_b, 80'd0);
    check_eq("b_async_flags", 80'({valid_b, lock_b, stb_err_b, mrk_err_b}), 80'd0);
    check_eq("b_async_cnt", 80'(cnt_b), 80'd0);
    rst_b_n = 1'b1;
    step(GOOD2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
